// File: rtl/sumsq_serial.sv
// Serial sum-of-squares: x*x + y*y via a one-bit-per-clock shift-add multiplier.
// The result is presented to the square-root stage over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SQ_X  | accumulating X*X, one multiplier bit per clock
// SQ_Y  | accumulating Y*Y into the same accumulator
// DONE  | result valid, holding until downstream accepts
module sumsq_serial #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH:0]   sumsq_out,
    output logic               busy
);

    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_X = 2'd1,
        SQ_Y = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [WIDTH-1:0] mcand;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  addend;
    logic [AW-1:0]  acc_sum;
    logic [CW-1:0]  cnt;
    logic           last_bit;

    // Each square uses the same operand as multiplicand and multiplier.
    assign mcand    = (state == SQ_Y) ? op_y : op_x;
    assign addend   = mcand[cnt] ? (AW'(mcand) << cnt) : '0;
    assign acc_sum  = acc + addend;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = SQ_X;
            SQ_X: if (last_bit) state_nxt = SQ_Y;
            SQ_Y: if (last_bit) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_x      <= '0;
            op_y      <= '0;
            acc       <= '0;
            cnt       <= '0;
            sumsq_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_x <= x_in;
                        op_y <= y_in;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                SQ_X: begin
                    acc <= acc_sum;
                    cnt <= last_bit ? '0 : cnt + CW'(1);
                end
                SQ_Y: begin
                    acc <= acc_sum;
                    cnt <= last_bit ? '0 : cnt + CW'(1);
                    if (last_bit) sumsq_out <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sumsq_serial.sv
// Bench for sumsq_serial: directed and random operands, scoreboard of x*x + y*y
// with accept-cycle stamps, monitor checks result, latency and hold-while-stalled.
module tb_sumsq_serial;

    localparam int WIDTH = 8;
    localparam int LAT   = 2 * WIDTH;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x_in;
    logic [WIDTH-1:0]   y_in;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH:0]   sumsq_out;
    logic               busy;

    sumsq_serial #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sumsq_out (sumsq_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned sum;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        prev_valid = 1'b0;
    logic [2*WIDTH:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: first rise of out_valid checks latency, stalled cycles check hold,
    // a handshake pops the scoreboard and checks the value.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check("unexpected_result", 1, 0);
                else check("latency", cyc - sb[0].acc_cyc, LAT);
            end
            if (out_valid && prev_valid) check("hold_sumsq", sumsq_out, held);
            if (out_valid && out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sumsq", sumsq_out, e.sum);
            end
            prev_valid = out_valid;
            held       = sumsq_out;
        end
    end

    task automatic send(input int unsigned x, input int unsigned y);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        x_in     = WIDTH'(x);
        y_in     = WIDTH'(y);
        in_valid = 1'b1;
        tick();
        sb.push_back('{x * x + y * y, cyc});
        in_valid = 1'b0;
        x_in     = WIDTH'($urandom);
        y_in     = WIDTH'($urandom);
        check("busy_after_accept", busy, 1);
        check("in_ready_after_accept", in_ready, 0);
    endtask

    task automatic wait_valid;
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic wait_done;
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check("result_timeout", sb.size(), 0);
            sb.delete();
        end
        check("in_ready_after_handshake", in_ready, 1);
        check("out_valid_after_handshake", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        y_in      = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_sumsq", sumsq_out, 0);

        send(3, 4);     wait_done();
        send(5, 12);    wait_done();
        send(0, 0);     wait_done();
        send(255, 255); wait_done();
        send(255, 0);   wait_done();

        // Stalled consumer with ignored in_valid pulses while DONE.
        out_ready = 1'b0;
        send(8, 15);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            x_in     = 8'd1;
            y_in     = 8'd2;
            tick();
            check("stall_out_valid", out_valid, 1);
            check("stall_sumsq", sumsq_out, 289);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_done();

        // New operands offered mid-computation must be ignored.
        send(6, 8);
        in_valid = 1'b1;
        x_in     = 8'd1;
        y_in     = 8'd1;
        repeat (4) tick();
        in_valid = 1'b0;
        wait_done();
        repeat (LAT + 4) tick();

        // Reset during SQ_X aborts the operation.
        send(9, 40);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_sumsq", sumsq_out, 0);
        repeat (LAT + 4) tick();
        send(7, 24);    wait_done();

        for (int t = 0; t < 25; t++) begin
            int unsigned stall;
            stall     = $urandom_range(0, 3);
            out_ready = (stall == 0);
            send($urandom_range(0, 255), $urandom_range(0, 255));
            if (stall != 0) begin
                wait_valid();
                repeat (stall) tick();
                out_ready = 1'b1;
            end
            wait_done();
        end

        repeat (5) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sumsq_serial.md
Name: sumsq_serial

Overview:
- Upstream stage of the Pythagoras datapath: computes x*x + y*y from two unsigned operands using a serial shift-add multiplier, one multiplier bit per clock.
- Presents the sum of squares over a valid/ready handshake to the iterative square-root stage, which produces sqrt(x^2+y^2).
- Trades latency (2*WIDTH cycles) for area, matching the bit-serial style of the sqrt stage.

Parameters:
WIDTH, 8, operand width in bits; result width is 2*WIDTH+1 (max 2*(2^WIDTH-1)^2 fits without overflow).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  operands valid; accepted when in_valid && in_ready at a rising edge
in_ready  output  1  high only in IDLE
x_in  input  WIDTH  unsigned operand X
y_in  input  WIDTH  unsigned operand Y
out_valid  output  1  result valid, held until consumed
out_ready  input  1  downstream accepts result
sumsq_out  output  2*WIDTH+1  x_in^2 + y_in^2 of the accepted operands
busy  output  1  high in SQ_X, SQ_Y or DONE

Behaviour:
- Reset (rst_n low at edge): state=IDLE, in_ready=1, out_valid=0, busy=0, sumsq_out=0, accumulator/counters/operand regs=0. Reset aborts any operation in progress; no partial result is ever emitted.
- States: IDLE, SQ_X, SQ_Y, DONE.
- IDLE: in_ready=1. At an edge with in_valid=1: latch x_in, y_in into operand regs, clear accumulator, bit counter=0, go SQ_X. With in_valid=0: stay.
- SQ_X: each edge, if multiplier bit[counter] of X is 1, acc += X << counter; counter++. After WIDTH edges (counter reaches WIDTH-1 and is processed) go SQ_Y with counter=0.
- SQ_Y: same shift-add using Y as multiplicand and multiplier, accumulating into the same acc. After WIDTH edges go DONE; sumsq_out <= final acc; out_valid <= 1 on that same edge.
- Latency: accept edge E0; out_valid first observed high after edge E0+2*WIDTH (16 cycles for WIDTH=8).
- DONE: out_valid=1, sumsq_out stable. At an edge with out_ready=1: out_valid<=0, go IDLE (in_ready high next cycle). While out_ready=0, state, out_valid and sumsq_out hold unchanged indefinitely.
- sumsq_out retains the last result after handshake until the next result is written (it is not cleared); consumers qualify it with out_valid.
- in_valid while in_ready=0 is ignored: no effect on operands, no queueing. Operand changes after acceptance do not affect the result.
- Throughput: one result per 2*WIDTH+2 cycles minimum (accept, compute, handshake, return to IDLE).
- Arithmetic: unsigned, accumulator 2*WIDTH+1 bits, never wraps for legal inputs.
- out_ready is don't-care outside DONE.

Test Plan:
- Reset, then x=3, y=4 with in_valid one cycle, out_ready=1 -> out_valid rises 16 cycles after accept, sumsq_out=25, out_valid drops one cycle later, in_ready=1.
- x=5, y=12 -> sumsq_out=169; then x=0, y=0 -> sumsq_out=0 with identical 16-cycle latency.
- x=255, y=255 -> sumsq_out=130050 (17 bits, no overflow); x=255, y=0 -> 65025.
- out_ready held low 5 cycles after out_valid for x=8, y=15 -> sumsq_out=289 stable and out_valid high throughout; in_valid pulses during that time ignored; result consumed on first out_ready=1 edge.
- in_valid asserted with new operands (x=1, y=1) during SQ_X of x=6, y=8 -> result is 100; no second result appears.
- rst_n low for one edge at cycle 7 of SQ_X -> next cycle out_valid=0, busy=0, in_ready=1, sumsq_out=0; a subsequent x=7, y=24 gives 625.
